// File: rtl/ltl_mon_pkg.sv
// Shared helpers for the LTL monitor cluster: event record sizing,
// counter saturation value and slice indexing for the flat buses.
package ltl_mon_pkg;

  // Event record is {timestamp, property mask}.
  function automatic int unsigned evt_rec_w(input int unsigned ts_w, input int unsigned np);
    return ts_w + np;
  endfunction

  // All-ones value of a w-bit counter (w capped at 64).
  function automatic logic [63:0] cnt_sat(input int unsigned w);
    if (w >= 64) return '1;
    return (64'd1 << w) - 64'd1;
  endfunction

  // Low bit of field idx in a flat bus of w-bit fields.
  function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned w);
    return idx * w;
  endfunction

endpackage

// File: rtl/ltl_evt_fifo.sv
// Shift-register event FIFO: the head always sits in entry 0, so the head
// output comes straight from a flop. Supports push and pop in one cycle,
// including push while full when a pop frees the slot.
module ltl_evt_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  parameter int LW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic [LW-1:0] level,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  shift_in [DEPTH];
  logic [LW-1:0] level_q;
  logic [LW-1:0] wr_idx;
  logic          push_ok, pop_ok;

  assign empty   = (level_q == '0);
  assign full    = (level_q == LW'(DEPTH));
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  // On a simultaneous pop everything shifts down one, so the tail slot moves too.
  assign wr_idx  = pop_ok ? level_q - 1'b1 : level_q;
  assign head    = mem_q[0];
  assign level   = level_q;

  for (genvar i = 0; i < DEPTH; i++) begin : g_shift
    if (i == DEPTH - 1) begin : g_last
      assign shift_in[i] = '0;
    end else begin : g_mid
      assign shift_in[i] = mem_q[i+1];
    end
  end

  // Entry storage: write at tail, shift toward head on pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (push_ok && wr_idx == LW'(i)) mem_q[i] <= push_data;
        else if (pop_ok)                 mem_q[i] <= shift_in[i];
      end
    end
  end

  // Occupancy tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  level_q <= '0;
    else if (flush)              level_q <= '0;
    else if (push_ok && !pop_ok) level_q <= level_q + 1'b1;
    else if (pop_ok && !push_ok) level_q <= level_q - 1'b1;
  end

endmodule

// File: rtl/ltl_monitor_cluster.sv
// Aggregates automaton report-state hits into per-property LTL verdicts,
// sticky flags, saturating hit counters and a timestamped event FIFO.
module ltl_monitor_cluster
  import ltl_mon_pkg::*;
#(
  parameter int NUM_PROPS  = 13,
  parameter int NUM_REPORT = 4,
  parameter int CNT_W      = 16,
  parameter int TS_W       = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          run,
  input  logic [NUM_PROPS*NUM_REPORT-1:0] report_hits,
  input  logic                          clear,
  output logic [NUM_PROPS-1:0]          ltl_hit,
  output logic [NUM_PROPS-1:0]          ltl_sticky,
  output logic [NUM_PROPS*CNT_W-1:0]    hit_count,
  output logic                          evt_valid,
  input  logic                          evt_ready,
  output logic [TS_W-1:0]               evt_ts,
  output logic [NUM_PROPS-1:0]          evt_mask,
  output logic [LVL_W-1:0]              evt_level,
  output logic                          evt_overflow
);

  localparam int unsigned REC_W = evt_rec_w(TS_W, NUM_PROPS);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_sat(CNT_W));

  logic [NUM_PROPS-1:0] hit_vec;
  logic [TS_W-1:0]      ts_q;
  logic [REC_W-1:0]     head;
  logic                 fifo_push, fifo_full, fifo_empty;

  // Per-property OR reduction and saturating counter.
  for (genvar p = 0; p < NUM_PROPS; p++) begin : g_prop
    localparam int unsigned HLO = slice_lo(p, NUM_REPORT);
    localparam int unsigned CLO = slice_lo(p, CNT_W);
    logic [CNT_W-1:0] cnt_q;

    assign hit_vec[p] = run & (|report_hits[HLO +: NUM_REPORT]);
    assign hit_count[CLO +: CNT_W] = cnt_q;

    // Count hits, holding at all-ones.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset)                              cnt_q <= '0;
      else if (clear)                          cnt_q <= '0;
      else if (hit_vec[p] && cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;
    end
  end

  // Verdicts: per-cycle and sticky.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ltl_hit    <= '0;
      ltl_sticky <= '0;
    end else if (clear) begin
      ltl_hit    <= '0;
      ltl_sticky <= '0;
    end else begin
      ltl_hit    <= hit_vec;
      ltl_sticky <= ltl_sticky | hit_vec;
    end
  end

  // Run-cycle timestamp; frozen while run is low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     ts_q <= '0;
    else if (clear) ts_q <= '0;
    else if (run)   ts_q <= ts_q + 1'b1;
  end

  assign fifo_push = (|hit_vec) & ~clear;

  // Drop flag: full FIFO with no pop frees no slot for the new record.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                     evt_overflow <= 1'b0;
    else if (clear)                                 evt_overflow <= 1'b0;
    else if (fifo_push && fifo_full && !evt_ready)  evt_overflow <= 1'b1;
  end

  ltl_evt_fifo #(
    .W     (REC_W),
    .DEPTH (FIFO_DEPTH),
    .LW    (LVL_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (reset),
    .flush     (clear),
    .push      (fifo_push),
    .push_data ({ts_q, hit_vec}),
    .pop       (evt_ready),
    .head      (head),
    .level     (evt_level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign evt_valid = ~fifo_empty;
  assign evt_ts    = head[REC_W-1 -: TS_W];
  assign evt_mask  = head[NUM_PROPS-1:0];

endmodule

// File: doc/ltl_monitor_cluster.md
# ltl_monitor_cluster

Parametrised successor to the fixed-size monitor-cluster top. It aggregates automaton report-state hits into per-property LTL verdicts for any number of properties and report states. It adds sticky verdicts, saturating per-property hit counters and a timestamped event FIFO drained over a valid/ready handshake. It sits between the automata stages of one cluster and the monitor readout logic.

## Interface
- NUM_PROPS, 13, number of LTL properties in the cluster (1..64)
- NUM_REPORT, 4, report states per property OR-reduced into one verdict (1..16)
- CNT_W, 16, width of each per-property hit counter
- TS_W, 32, width of the run-cycle timestamp
- FIFO_DEPTH, 8, event FIFO entries (power of two, >=2)
- clk  in  1  clock; all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- run  in  1  symbol-valid qualifier from the automata stage; hits are ignored and the timestamp is frozen while low
- report_hits  in  NUM_PROPS*NUM_REPORT  report-state hits; bit p*NUM_REPORT+r is report state r of property p
- clear  in  1  synchronous clear of sticky flags, counters, timestamp, overflow and FIFO
- ltl_hit  out  NUM_PROPS  registered per-cycle verdict
- ltl_sticky  out  NUM_PROPS  sticky verdict since reset/clear
- hit_count  out  NUM_PROPS*CNT_W  saturating hit count per property; field p at [p*CNT_W +: CNT_W]
- evt_valid  out  1  event FIFO head valid
- evt_ready  in  1  consumer accepts head
- evt_ts  out  TS_W  timestamp of head event
- evt_mask  out  NUM_PROPS  properties that fired in head event
- evt_level  out  $clog2(FIFO_DEPTH+1)  current FIFO occupancy
- evt_overflow  out  1  sticky: at least one event was dropped because the FIFO was full

## Operation
- hit_vec[p] = run & OR over r of report_hits[p*NUM_REPORT+r].
- ltl_hit <= hit_vec every cycle. It is zero on the cycle after clear.
- ltl_sticky <= ltl_sticky | hit_vec.
- hit_count[p] increments by 1 when hit_vec[p]=1. It saturates at all-ones and holds there (no wrap).
- Timestamp ts increments when run=1 and wraps modulo 2^TS_W. Events carry ts as sampled in the hit cycle, i.e. before the increment.
- Event push: when |hit_vec=1, the record {ts, hit_vec} is pushed. There is one record per cycle, and a multi-property cycle gives one record with several mask bits.
- Push while full with no pop that cycle: the record is dropped and evt_overflow <= 1. Counters and sticky flags still update.
- Pop: the head is consumed on evt_valid & evt_ready. evt_ts and evt_mask are only meaningful while evt_valid=1.
- Push and pop in the same cycle when full: both are accepted, and the level is unchanged.
- clear (priority over everything): sticky, counters, ts, overflow and ltl_hit go to 0 and the FIFO is flushed. Hits in the clear cycle are discarded.
- Reset values: every output is 0. FIFO empty, ts=0.
- Reset mid-operation: the asynchronous assertion immediately zeroes all state, and any in-flight events are lost.

## Timing
- ltl_hit, ltl_sticky and hit_count update 1 cycle after the hit cycle.
- Event latency: hit in cycle t gives evt_valid=1 in cycle t+1 if the FIFO was empty. No bypass inside the same cycle.
- evt_level reflects pushes and pops at the next edge.
- evt_valid, once high, stays high with stable evt_ts and evt_mask until popped. The only exceptions are clear and reset.
- Throughput: 1 push and 1 pop per cycle.

## Structure
- Package ltl_mon_pkg holds:
  - the event record width function (TS_W+NUM_PROPS)
  - the counter saturation constant helper
  - the index helper for the report_hits and hit_count slices
- Sub-module ltl_evt_fifo is a synchronous FIFO with registered head output, level output, flush input, and full/empty flags. It is parametrised by width and depth.
- The top holds the reduction, sticky flags, counters, timestamp and overflow logic.

## Test plan
- Reset then idle with run=1 for 10 cycles: all outputs 0, ts=10. Hit property 0 in the next cycle: evt_valid=1 one cycle later with evt_ts=10, evt_mask=1.
- run=0 with all report_hits=1 for 5 cycles: no verdicts, no events, ts frozen. Then run=1 for 1 cycle with all hits: evt_mask=all ones, ltl_sticky=all ones, each hit_count=1.
- CNT_W=4 with property 2 hit for 20 consecutive cycles: hit_count[2] reaches 15 and holds, and the other counters stay 0.
- evt_ready=0 with FIFO_DEPTH+3 hit cycles: evt_level=FIFO_DEPTH and evt_overflow=1. Draining returns exactly FIFO_DEPTH records with consecutive timestamps, oldest first.
- FIFO full with simultaneous hit and pop: level is unchanged, overflow stays 0, and the new record is last.
- clear together with hits in the same cycle: next cycle all state is 0, the FIFO is empty, and the hits are not counted. Separately, asserting reset while the FIFO is half full zeroes all outputs immediately.
